keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 159 +++++++++++++++
 tb/tb_keypad_scan.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and a four-key history.
//
// Drives one column low at a time and samples the (synchronised) row lines once
// per ce_1ms tick. A low row starts a debounce; a key that stays down for
// DEBOUNCE_MS samples is accepted, reported on key/key_vld and shifted into dat.
// The scanner then freezes on that key until its release is debounced too.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   ce_1ms   one-clk strobe per millisecond; all decisions happen on it
//   row      keypad rows, active-low, asynchronous to clk
//   col      keypad column drive, active-low one-hot
//   key      code {row, col} of the last accepted key
//   key_vld  one-clk strobe for a newly accepted key
//   pressed  high while an accepted key is held or its release is debounced
//   dat      last four accepted key codes, newest in dat[3:0]
module keypad_scan #(
  parameter int unsigned DEBOUNCE_MS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_1ms,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key,
  output logic        key_vld,
  output logic        pressed,
  output logic [15:0] dat
);

  localparam logic [7:0] DebLim = 8'(DEBOUNCE_MS);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHold,
    StRelease
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  rs1_q, rs_q;
  logic [1:0]  ci_q, ci_d;
  logic [1:0]  ri_q, ri_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  key_q, key_d;
  logic [15:0] dat_q, dat_d;
  logic        key_vld_q, key_vld_d;
  logic        pressed_q, pressed_d;
  logic [3:0]  col_q, col_d;
  logic [1:0]  low_idx;

  // Lowest-index low row bit; only meaningful when rs_q != 4'hF.
  always_comb begin
    if (!rs_q[0]) begin
      low_idx = 2'd0;
    end else if (!rs_q[1]) begin
      low_idx = 2'd1;
    end else if (!rs_q[2]) begin
      low_idx = 2'd2;
    end else begin
      low_idx = 2'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    ci_d      = ci_q;
    ri_d      = ri_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    dat_d     = dat_q;
    key_vld_d = 1'b0;

    if (ce_1ms) begin
      unique case (state_q)
        StScan: begin
          if (rs_q == 4'hF) begin
            ci_d = ci_q + 2'd1;
          end else begin
            ri_d    = low_idx;
            cnt_d   = 8'd1;
            state_d = StDebounce;
          end
        end
        StDebounce: begin
          if (rs_q[ri_q]) begin
            // Bounce or glitch: drop it and move on to the next column.
            state_d = StScan;
            ci_d    = ci_q + 2'd1;
          end else if (cnt_q >= DebLim) begin
            state_d   = StHold;
            key_d     = {ri_q, ci_q};
            dat_d     = {dat_q[11:0], ri_q, ci_q};
            key_vld_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        StHold: begin
          if (rs_q[ri_q]) begin
            cnt_d   = 8'd1;
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (!rs_q[ri_q]) begin
            // Key bounced back down: restart the release count.
            cnt_d = 8'd0;
          end else if (cnt_q >= DebLim) begin
            state_d = StScan;
            ci_d    = ci_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: state_d = StScan;
      endcase
    end

    pressed_d = (state_d == StHold) || (state_d == StRelease);
    col_d     = ~(4'b0001 << ci_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q     <= 4'hF;
      rs_q      <= 4'hF;
      state_q   <= StScan;
      ci_q      <= 2'd0;
      ri_q      <= 2'd0;
      cnt_q     <= 8'd0;
      key_q     <= 4'd0;
      dat_q     <= 16'h0000;
      key_vld_q <= 1'b0;
      pressed_q <= 1'b0;
      col_q     <= 4'b1110;
    end else begin
      rs1_q     <= row;
      rs_q      <= rs1_q;
      state_q   <= state_d;
      ci_q      <= ci_d;
      ri_q      <= ri_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      dat_q     <= dat_d;
      key_vld_q <= key_vld_d;
      pressed_q <= pressed_d;
      col_q     <= col_d;
    end
  end

  assign col     = col_q;
  assign key     = key_q;
  assign key_vld = key_vld_q;
  assign pressed = pressed_q;
  assign dat     = dat_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan (DEBOUNCE_MS = 3). A small keypad model pulls one row
// low while its column is driven. Each expected accepted key {key, dat} is
// queued when the press is issued; a monitor pops and compares on key_vld.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_1ms = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_vld;
  logic        pressed;
  logic [15:0] dat;

  logic        press_on = 1'b0;
  logic [1:0]  press_r = 2'd0;
  logic [1:0]  press_c = 2'd0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];
  logic [15:0] exp_dat = 16'h0000;

  always #5 clk = ~clk;

  // Matrix model: the pressed key connects its column to its row.
  assign row = (press_on && (col[press_c] == 1'b0)) ? ~(4'b0001 << press_r) : 4'hF;

  keypad_scan #(.DEBOUNCE_MS(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce_1ms  (ce_1ms),
    .row     (row),
    .col     (col),
    .key     (key),
    .key_vld (key_vld),
    .pressed (pressed),
    .dat     (dat)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Let the row lines settle through the synchroniser, then pulse ce_1ms.
  task automatic tick();
    repeat (4) @(posedge clk);
    #1 ce_1ms = 1'b1;
    @(posedge clk);
    #1 ce_1ms = 1'b0;
  endtask

  task automatic expect_key(input logic [1:0] r, input logic [1:0] c);
    exp_dat = {exp_dat[11:0], r, c};
    exp_q.push_back({r, c, exp_dat});
  endtask

  // Full press/release of one key with bounded waits.
  task automatic press_key(input logic [1:0] r, input logic [1:0] c);
    expect_key(r, c);
    press_r  = r;
    press_c  = c;
    press_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pressed) break;
    end
    check("press_accept", {15'd0, pressed}, 16'd1);
    press_on = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!pressed) break;
    end
    check("release_done", {15'd0, pressed}, 16'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col"}, {12'd0, col}, 16'h000E);
    check({tag, "_key"}, {12'd0, key}, 16'h0000);
    check({tag, "_vld"}, {15'd0, key_vld}, 16'd0);
    check({tag, "_pressed"}, {15'd0, pressed}, 16'd0);
    check({tag, "_dat"}, dat, 16'h0000);
  endtask

  // Monitor: every key_vld must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (key_vld) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_key_vld: got key=%h dat=%h expected none", key, dat);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if ({key, dat} !== e) begin
            n_fail++;
            $display("FAIL key_vld_data: got key=%h dat=%h expected key=%h dat=%h",
                     key, dat, e[19:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] col_seq [4];
    col_seq[0] = 4'b1110;
    col_seq[1] = 4'b1101;
    col_seq[2] = 4'b1011;
    col_seq[3] = 4'b0111;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Idle scan: column walks and wraps, no key_vld.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_col", {12'd0, col}, {12'd0, col_seq[(i + 1) % 4]});
    end

    // Key A: row 2 / column 2, ci back at 0.
    expect_key(2'd2, 2'd2);
    press_r = 2'd2; press_c = 2'd2; press_on = 1'b1;
    tick(); tick();
    check("a_col_found", {12'd0, col}, 16'h000B);
    tick(); tick(); tick();
    check("a_pressed_before", {15'd0, pressed}, 16'd0);
    tick();
    check("a_vld", {15'd0, key_vld}, 16'd1);
    check("a_key", {12'd0, key}, 16'h000A);
    check("a_dat", dat, 16'h000A);
    check("a_pressed", {15'd0, pressed}, 16'd1);
    press_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_release_pressed", {15'd0, pressed}, 16'd1);
      check("a_release_col", {12'd0, col}, 16'h000B);
    end
    tick();
    check("a_released", {15'd0, pressed}, 16'd0);
    check("a_next_col", {12'd0, col}, 16'h0007);

    // Short press in column 1: aborts, scan resumes at column 2.
    tick(); tick();
    check("short_col1", {12'd0, col}, 16'h000D);
    press_r = 2'd0; press_c = 2'd1; press_on = 1'b1;
    tick(); tick();
    press_on = 1'b0;
    tick();
    check("short_abort_col", {12'd0, col}, 16'h000B);
    check("short_pressed", {15'd0, pressed}, 16'd0);

    // Keys 1..5 in sequence.
    press_key(2'd0, 2'd1);
    press_key(2'd0, 2'd2);
    press_key(2'd0, 2'd3);
    press_key(2'd1, 2'd0);
    press_key(2'd1, 2'd1);
    check("seq_dat", dat, 16'h2345);
    check("seq_key", {12'd0, key}, 16'h0005);

    // Key 6 with release bounce; col ends at ci=2 after key 5.
    expect_key(2'd1, 2'd2);
    press_r = 2'd1; press_c = 2'd2; press_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pressed) break;
    end
    check("b_accept", {15'd0, pressed}, 16'd1);
    press_on = 1'b0; tick();
    check("b_rel1", {15'd0, pressed}, 16'd1);
    press_on = 1'b1; tick();
    check("b_bounce1", {15'd0, pressed}, 16'd1);
    press_on = 1'b0; tick(); tick();
    check("b_rel2", {15'd0, pressed}, 16'd1);
    press_on = 1'b1; tick();
    check("b_bounce2", {15'd0, pressed}, 16'd1);
    press_on = 1'b0; tick(); tick(); tick();
    check("b_rel3", {15'd0, pressed}, 16'd1);
    tick();
    check("b_released", {15'd0, pressed}, 16'd0);
    check("b_dat", dat, 16'h3456);
    check("b_col", {12'd0, col}, 16'h0007);

    // Reset mid-debounce on column 3.
    press_r = 2'd3; press_c = 2'd3; press_on = 1'b1;
    tick(); tick();
    check("rd_col_frozen", {12'd0, col}, 16'h0007);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_debounce");
    press_on = 1'b0;
    exp_dat = 16'h0000;
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset asynchronously while holding key 9 (row 2, column 1).
    expect_key(2'd2, 2'd1);
    press_r = 2'd2; press_c = 2'd1; press_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pressed) break;
    end
    check("rh_accept", {15'd0, pressed}, 16'd1);
    check("rh_dat", dat, 16'h0009);
    tick();
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_hold");
    press_on = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick(); tick();
    check("post_rst_pressed", {15'd0, pressed}, 16'd0);

    repeat (3) @(posedge clk);
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
